// File: rtl/shape_prog_ctrl.sv
// Buffers UART program packets in a small FIFO and commits them to the shape
// register bank only while the renderer is idle, discarding out-of-range shapes.
module shape_prog_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_SHAPES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              program_in,
    input  logic [ADDR_W-1:0] shape_addr_in,
    input  logic [ADDR_W-1:0] reg_addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              frame_busy,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_shape,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic [7:0]        drop_count,
    output logic [1:0]        state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  MAX_S    = (ADDR_W + 1)'(MAX_SHAPES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] shape_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] reg_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;
    logic head_ok;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign state_dbg  = state;

    // Fullness uses the registered count, so a pop in the same cycle never makes room.
    assign push    = program_in & ~fifo_full;
    assign pop     = (state == S_IDLE) & ~fifo_empty & ~frame_busy;
    assign head_ok = ({1'b0, shape_mem[rd_ptr]} < MAX_S);

    // Storage holds no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            shape_mem[wr_ptr] <= shape_addr_in;
            reg_mem[wr_ptr]   <= reg_addr_in;
            data_mem[wr_ptr]  <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (program_in && fifo_full) overflow <= 1'b1;
        end
    end

    // Bank handshake: wr_en with wr_* is held stable until the bank raises
    // wr_ready; the write commits on the edge where both are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_en      <= 1'b0;
            wr_shape   <= '0;
            wr_reg     <= '0;
            wr_data    <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wr_en <= 1'b0;
                    if (pop) begin
                        if (head_ok) begin
                            wr_shape <= shape_mem[rd_ptr];
                            wr_reg   <= reg_mem[rd_ptr];
                            wr_data  <= data_mem[rd_ptr];
                            wr_en    <= 1'b1;
                            state    <= S_ISSUE;
                        end else if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    wr_en <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    wr_en <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shape_prog_ctrl.sv
// Bench for shape_prog_ctrl: directed scenarios plus randomized bursts checked
// against a packet-level model of which packets must reach the bank.
module tb_shape_prog_ctrl;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int DEPTH = 8;
  localparam int MAXS = 16;
  localparam int W = 2 * AW + DW;

  logic clk, rst, program_in, frame_busy, wr_en, wr_ready;
  logic [AW-1:0] shape_addr_in, reg_addr_in, wr_shape, wr_reg;
  logic [DW-1:0] data_in, wr_data;
  logic fifo_full, fifo_empty, overflow;
  logic [7:0] drop_count;
  logic [1:0] state_dbg;

  shape_prog_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_SHAPES(MAXS)) dut (
    .clk(clk), .rst(rst), .program_in(program_in), .shape_addr_in(shape_addr_in),
    .reg_addr_in(reg_addr_in), .data_in(data_in), .frame_busy(frame_busy),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_shape(wr_shape), .wr_reg(wr_reg),
    .wr_data(wr_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .overflow(overflow), .drop_count(drop_count), .state_dbg(state_dbg)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int got_cyc[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // commit monitor: a write commits on the edge after wr_en & wr_ready are seen here
  always @(negedge clk) begin
    if (!rst && wr_en && wr_ready) begin
      got_q.push_back({wr_shape, wr_reg, wr_data});
      got_cyc.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_queues();
  endtask

  task automatic push_pkt(input logic [AW-1:0] s, input logic [AW-1:0] r, input logic [DW-1:0] d);
    program_in = 1'b1;
    shape_addr_in = s;
    reg_addr_in = r;
    data_in = d;
    tick();
    program_in = 1'b0;
  endtask

  task automatic wait_drain(output bit timed_out);
    int n = 0;
    while (!(fifo_empty && !wr_en) && n < 300) begin
      tick();
      n++;
    end
    timed_out = (n >= 300);
    repeat (3) tick();
  endtask

  function automatic int queue_diff();
    if (got_q.size() != exp_q.size()) return 9999;
    for (int i = 0; i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_pkt(input int lo, input int hi);
    logic [AW-1:0] s;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    s = AW'($urandom_range(lo, hi));
    r = AW'($urandom);
    d = DW'($urandom);
    return {s, r, d};
  endfunction

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({wr_en, fifo_full, overflow, drop_count, wr_shape, wr_reg, wr_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b full=%b ovf=%b drop=%0d wr=%h/%h/%h, expected all 0",
               wr_en, fifo_full, overflow, drop_count, wr_shape, wr_reg, wr_data);
    end
    tests_run++;
    if (fifo_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_empty: got %b expected 1", fifo_empty);
    end
    rst = 1'b0;
    tick();
    clear_queues();
  endtask

  task automatic test_single();
    int d;
    frame_busy = 1'b0;
    wr_ready = 1'b1;
    clear_queues();
    push_pkt(12'd3, 12'd5, 12'hABC);
    tests_run++;
    if (fifo_empty !== 1'b0 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_stored: got empty=%b en=%b expected empty=0 en=0", fifo_empty, wr_en);
    end
    tick();
    tests_run++;
    if (wr_en !== 1'b1 || {wr_shape, wr_reg, wr_data} !== {12'd3, 12'd5, 12'hABC}) begin
      tests_failed++;
      $display("FAIL single_issue: got en=%b %h/%h/%h expected en=1 003/005/abc",
               wr_en, wr_shape, wr_reg, wr_data);
    end
    tick();
    tests_run++;
    if (wr_en !== 1'b0 || fifo_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_done: got en=%b empty=%b expected en=0 empty=1", wr_en, fifo_empty);
    end
    repeat (4) tick();
    exp_q.push_back({12'd3, 12'd5, 12'hABC});
    d = queue_diff();
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL single_writes: got %0d writes expected 1 (first diff %0d)", got_q.size(), d);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] p;
    bit to;
    int d;
    clear_queues();
    frame_busy = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      p = rand_pkt(0, MAXS - 1);
      exp_q.push_back(p);
      push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    end
    repeat (2) tick();
    tests_run++;
    if (fifo_full !== 1'b1 || wr_en !== 1'b0 || overflow !== 1'b0 || got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ovf_fill: got full=%b en=%b ovf=%b writes=%0d expected full=1 en=0 ovf=0 writes=0",
               fifo_full, wr_en, overflow, got_q.size());
    end
    p = rand_pkt(0, MAXS - 1);
    push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    frame_busy = 1'b0;
    wait_drain(to);
    d = queue_diff();
    tests_run++;
    if (to || d != -1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_drain: got timeout=%b writes=%0d diff=%0d ovf=%b expected 0/8/-1/1",
               to, got_q.size(), d, overflow);
    end
  endtask

  task automatic test_range();
    logic [W-1:0] p;
    bit to;
    int d;
    clear_queues();
    frame_busy = 1'b0;
    wr_ready = 1'b1;
    push_pkt(12'd1, 12'd7, 12'h111);
    push_pkt(12'd16, 12'd7, 12'h222);
    push_pkt(12'd2, 12'd8, 12'h333);
    push_pkt(12'd15, 12'd9, 12'h444);
    exp_q.push_back({12'd1, 12'd7, 12'h111});
    exp_q.push_back({12'd2, 12'd8, 12'h333});
    exp_q.push_back({12'd15, 12'd9, 12'h444});
    wait_drain(to);
    d = queue_diff();
    tests_run++;
    if (to || d != -1 || drop_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL range_filter: got timeout=%b writes=%0d diff=%0d drop=%0d expected 0/3/-1/1",
               to, got_q.size(), d, drop_count);
    end
    clear_queues();
    for (int i = 0; i < 300; i++) begin
      p = rand_pkt(MAXS, 4095);
      push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    end
    wait_drain(to);
    tests_run++;
    if (to || got_q.size() != 0 || drop_count !== 8'hFF) begin
      tests_failed++;
      $display("FAIL range_saturate: got timeout=%b writes=%0d drop=%0d expected 0/0/255",
               to, got_q.size(), drop_count);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit unstable;
    bit leaked;
    bit to;
    int d;
    clear_queues();
    a = rand_pkt(0, MAXS - 1);
    b = rand_pkt(0, MAXS - 1);
    frame_busy = 1'b0;
    wr_ready = 1'b0;
    push_pkt(a[W-1-:AW], a[DW+AW-1-:AW], a[DW-1:0]);
    tick();
    frame_busy = 1'b1;
    unstable = 1'b0;
    push_pkt(b[W-1-:AW], b[DW+AW-1-:AW], b[DW-1:0]);
    for (int i = 0; i < 4; i++) begin
      if (wr_en !== 1'b1 || {wr_shape, wr_reg, wr_data} !== a) unstable = 1'b1;
      tick();
    end
    tests_run++;
    if (unstable || wr_en !== 1'b1 || {wr_shape, wr_reg, wr_data} !== a) begin
      tests_failed++;
      $display("FAIL stall_hold: got en=%b wr=%h unstable=%b expected en=1 wr=%h", wr_en,
               {wr_shape, wr_reg, wr_data}, unstable, a);
    end
    wr_ready = 1'b1;
    tick();
    leaked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (wr_en !== 1'b0) leaked = 1'b1;
      tick();
    end
    exp_q.push_back(a);
    d = queue_diff();
    tests_run++;
    if (leaked || d != -1) begin
      tests_failed++;
      $display("FAIL stall_commit: got leaked=%b writes=%0d diff=%0d expected 0/1/-1",
               leaked, got_q.size(), d);
    end
    frame_busy = 1'b0;
    wait_drain(to);
    exp_q.push_back(b);
    d = queue_diff();
    tests_run++;
    if (to || d != -1) begin
      tests_failed++;
      $display("FAIL stall_resume: got timeout=%b writes=%0d diff=%0d expected 0/2/-1", to, got_q.size(), d);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p;
    bit to;
    bit bad_gap;
    int d;
    clear_queues();
    frame_busy = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = rand_pkt(0, MAXS - 1);
      exp_q.push_back(p);
      push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    end
    frame_busy = 1'b0;
    wait_drain(to);
    d = queue_diff();
    bad_gap = 1'b0;
    for (int i = 1; i < got_cyc.size(); i++)
      if (got_cyc[i] - got_cyc[i-1] != 3) bad_gap = 1'b1;
    tests_run++;
    if (to || d != -1 || bad_gap) begin
      tests_failed++;
      $display("FAIL back_to_back: got timeout=%b writes=%0d diff=%0d bad_spacing=%b expected 0/4/-1/0",
               to, got_q.size(), d, bad_gap);
    end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] p;
    bit to;
    int d;
    do_reset();
    frame_busy = 1'b1;
    wr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      p = rand_pkt(0, MAXS - 1);
      exp_q.push_back(p);
      push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    end
    frame_busy = 1'b0;
    p = rand_pkt(0, MAXS - 1);
    push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    frame_busy = 1'b1;
    tests_run++;
    if (overflow !== 1'b1 || fifo_full !== 1'b0 || wr_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL pushpop_drop: got ovf=%b full=%b en=%b expected 1/0/1", overflow, fifo_full, wr_en);
    end
    p = rand_pkt(0, MAXS - 1);
    exp_q.push_back(p);
    push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    tests_run++;
    if (fifo_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL pushpop_count: got full=%b expected 1 (count back to depth)", fifo_full);
    end
    wr_ready = 1'b1;
    frame_busy = 1'b0;
    wait_drain(to);
    d = queue_diff();
    tests_run++;
    if (to || d != -1) begin
      tests_failed++;
      $display("FAIL pushpop_order: got timeout=%b writes=%0d diff=%0d expected 0/9/-1", to, got_q.size(), d);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] p;
    bit to;
    int d;
    do_reset();
    frame_busy = 1'b0;
    wr_ready = 1'b1;
    push_pkt(12'd40, 12'd1, 12'h001);
    repeat (3) tick();
    frame_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      p = rand_pkt(0, MAXS - 1);
      push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    end
    wr_ready = 1'b0;
    frame_busy = 1'b0;
    tick();
    tick();
    tests_run++;
    if (wr_en !== 1'b1 || overflow !== 1'b1 || drop_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL rstmid_setup: got en=%b ovf=%b drop=%0d expected 1/1/1", wr_en, overflow, drop_count);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (wr_en !== 1'b0 || fifo_empty !== 1'b1 || drop_count !== 8'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got en=%b empty=%b drop=%0d ovf=%b expected 0/1/0/0",
               wr_en, fifo_empty, drop_count, overflow);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_queues();
    wr_ready = 1'b1;
    repeat (10) tick();
    tests_run++;
    if (got_q.size() != 0 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: got writes=%0d en=%b expected 0/0", got_q.size(), wr_en);
    end
    p = rand_pkt(0, MAXS - 1);
    exp_q.push_back(p);
    push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
    wait_drain(to);
    d = queue_diff();
    tests_run++;
    if (to || d != -1) begin
      tests_failed++;
      $display("FAIL rstmid_new: got timeout=%b writes=%0d diff=%0d expected 0/1/-1", to, got_q.size(), d);
    end
  endtask

  // Bursts loaded while the renderer is busy; the model decides acceptance
  // (first DEPTH of a burst), range filtering, drop saturation and overflow.
  task automatic test_random();
    logic [W-1:0] p;
    int n;
    int m_drops;
    bit m_ovf;
    int k;
    int d;
    do_reset();
    m_drops = 0;
    m_ovf = 1'b0;
    for (int round = 0; round < 8; round++) begin
      clear_queues();
      frame_busy = 1'b1;
      wr_ready = 1'b1;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        p = rand_pkt(0, 23);
        push_pkt(p[W-1-:AW], p[DW+AW-1-:AW], p[DW-1:0]);
        repeat ($urandom_range(0, 2)) tick();
        if (i >= DEPTH) m_ovf = 1'b1;
        else if (p[W-1-:AW] < MAXS) exp_q.push_back(p);
        else if (m_drops < 255) m_drops++;
      end
      k = 0;
      while (!(fifo_empty && !wr_en) && k < 600) begin
        wr_ready = 1'($urandom_range(0, 1));
        frame_busy = ($urandom_range(0, 3) == 0);
        tick();
        k++;
      end
      wr_ready = 1'b1;
      frame_busy = 1'b0;
      repeat (4) tick();
      d = queue_diff();
      tests_run++;
      if (k >= 600 || d != -1 || drop_count !== 8'(m_drops) || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL random_round%0d: got writes=%0d diff=%0d drop=%0d ovf=%b expected writes=%0d drop=%0d ovf=%b timeout=%b",
                 round, got_q.size(), d, drop_count, overflow, exp_q.size(), m_drops, m_ovf, k >= 600);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    program_in = 1'b0;
    shape_addr_in = '0;
    reg_addr_in = '0;
    data_in = '0;
    frame_busy = 1'b0;
    wr_ready = 1'b1;
    #2;
    test_reset();
    test_single();
    test_overflow();
    test_range();
    test_stall();
    test_back_to_back();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
